// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first subtractor, diff = (a - b) mod 2^WIDTH.
// Optional signed overflow flag built when SUB_SIGNED_OVF_EN is defined.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   a, b   : minuend / subtrahend, sampled on an accepted start
//   start  : request a subtraction (IDLE, or DONE together with ack)
//   ack    : consumer acknowledge of the presented result
//   busy   : high in SHIFT or DONE
//   valid  : high in DONE
//   diff   : registered result, held until the next DONE entry
//   borrow : registered borrow-out, 1 iff a < b
//   ovf    : signed overflow flag (constant 0 unless SUB_SIGNED_OVF_EN)
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             accept;
    logic             last_bit;
    logic             ai, bi, d, br_d;
    logic [WIDTH-1:0] r_d;

    // A new operation is taken from IDLE, or from DONE only when the
    // current result is acknowledged on the same edge.
    assign accept   = start && ((state_q == IDLE) ||
                                ((state_q == DONE) && ack));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    assign ai   = a_sh_q[0];
    assign bi   = b_sh_q[0];
    assign d    = ai ^ bi ^ br_q;
    assign br_d = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign r_d  = {d, r_sh_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE: begin
                if (accept) begin
                    state_d = SHIFT;
                end else if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state_q != IDLE);
        valid = (state_q == DONE);
    end

    // Datapath: operand/result shift registers and the result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh_q <= a;
            b_sh_q <= b;
            r_sh_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
        end else if (state_q == SHIFT) begin
            a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
            r_sh_q <= r_d;
            br_q   <= br_d;
            if (last_bit) begin
                cnt_q    <= '0;
                diff_q   <= r_d;
                borrow_q <= br_d;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SUB_SIGNED_OVF_EN
    logic a_msb_q, b_msb_q, ovf_q;

    // The shift registers lose the operand MSBs, so keep them aside.
    // On the last bit, d is the MSB of the completed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
        end else if ((state_q == SHIFT) && last_bit) begin
            ovf_q <= (a_msb_q != b_msb_q) && (d != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for serial_subtractor.
// Expected results are queued at issue and checked by a separate monitor.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic [3:0] a, b;
    logic       start, ack;
    logic       busy, valid;
    logic [3:0] diff;
    logic       borrow, ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] d;
        logic       br;
        logic       ov;
    } res_t;

    res_t exp_q[$];
    res_t cur;
    logic vprev;
    int   popped = 0;
    int   pushed = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .start  (start),
        .ack    (ack),
        .busy   (busy),
        .valid  (valid),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Hand-computed overflow only exists in the signed-overflow build.
    function automatic logic sel_ovf(input logic o);
`ifdef SUB_SIGNED_OVF_EN
        return o;
`else
        return 1'b0 & o;
`endif
    endfunction

    task automatic push(input logic [3:0] d, input logic br, input logic o);
        res_t r;
        r.d  = d;
        r.br = br;
        r.ov = sel_ovf(o);
        exp_q.push_back(r);
        pushed++;
    endtask

    // Monitor: pop on each new presentation, then hold-check while valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            vprev <= 1'b0;
        end else begin
            if (valid && !vprev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    popped++;
                    chk("diff", 32'(diff), 32'(cur.d));
                    chk("borrow", 32'(borrow), 32'(cur.br));
                    chk("ovf", 32'(ovf), 32'(cur.ov));
                end
            end else if (valid) begin
                chk("hold", 32'({diff, borrow, ovf}),
                    32'({cur.d, cur.br, cur.ov}));
            end
            vprev <= valid;
        end
    end

    // Wait for valid with a bound; returns cycles after the start edge.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid && cyc < 20) begin
            chk("busy_in_shift", 32'(busy), 32'd1);
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd4);
    endtask

    task automatic issue(input logic [3:0] av, input logic [3:0] bv);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("valid_after_ack", 32'(valid), 32'd0);
    endtask

    task automatic run(input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] ed, input logic eb, input logic eo,
                       input int hold);
        int cyc;
        push(ed, eb, eo);
        issue(av, bv);
        wait_valid(cyc);
        repeat (hold) @(posedge clk);
        #1;
        do_ack();
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; a = '0; b = '0; start = 1'b0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 32'({busy, valid, diff, borrow, ovf}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 9-3 with a 3-cycle hold before ack
        run(4'd9, 4'd3, 4'd6, 1'b0, 1'b1, 3);

        // reset during SHIFT aborts and clears everything
        issue(4'd9, 4'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 32'({busy, valid, diff, borrow, ovf}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_idle", 32'({busy, valid}), 32'd0);

        run(4'd3, 4'd9, 4'hA, 1'b1, 1'b1, 0);
        run(4'd5, 4'd5, 4'd0, 1'b0, 1'b0, 1);
        run(4'd0, 4'd15, 4'd1, 1'b1, 1'b0, 0);

        // start and operands changing during SHIFT are ignored
        push(4'd6, 1'b0, 1'b1);
        issue(4'd9, 4'd3);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ignored_latency", 32'(cyc), 32'd2);

        // back-to-back: ack and start together from DONE
        push(4'd7, 1'b0, 1'b1);
        a = 4'd8; b = 4'd1; start = 1'b1; ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ack = 1'b0;
        chk("b2b_valid_drop", 32'(valid), 32'd0);
        wait_valid(cyc);
        do_ack();

        repeat (2) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("results_seen", 32'(popped), 32'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
